// File: rtl/car_warn_pkg.sv
// Shared constants for the cabin warning controller: switch bit positions,
// input count and debounce counter width, plus the warning function itself.
package car_warn_pkg;

  localparam int NUM_IN = 5;
  localparam int DB_W   = 8;

  localparam int IDX_E = 0;
  localparam int IDX_D = 1;
  localparam int IDX_B = 2;
  localparam int IDX_S = 3;
  localparam int IDX_H = 4;

  // Any of the three hazards sounds the buzzer; no priority between them.
  function automatic logic warn_fn(input logic [NUM_IN-1:0] v);
    logic w_lights;
    logic w_belt;
    logic w_door;
    w_lights = v[IDX_H] & v[IDX_D] & ~v[IDX_E];
    w_belt   = v[IDX_E] & ~v[IDX_S];
    w_door   = v[IDX_E] & v[IDX_D] & ~v[IDX_B];
    return w_lights | w_belt | w_door;
  endfunction

endpackage

// File: rtl/switch_filter.sv
// One vehicle switch: 2-flop synchronizer followed by an optional
// consecutive-cycle debounce filter (DEBOUNCE = 0 passes the synced bit through).
module switch_filter
  import car_warn_pkg::*;
#(
  parameter int DEBOUNCE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  output logic o_filt
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      assign o_filt = r_sync2;
    end else begin : g_debounce
      logic [DB_W-1:0] r_cnt;
      logic            r_filt;
      logic [DB_W-1:0] w_cnt_inc;
      logic [DB_W-1:0] w_limit;

      assign w_cnt_inc = r_cnt + 1'b1;
      assign w_limit   = DB_W'(DEBOUNCE);

      // Accept on the Nth consecutive differing cycle, so a level held
      // stable reaches the filtered output exactly N edges after sync.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (r_sync2 == r_filt) begin
          r_cnt <= '0;
        end else if (w_cnt_inc == w_limit) begin
          r_filt <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end

      assign o_filt = r_filt;
    end
  endgenerate

endmodule

// File: rtl/half_adder.sv
// Car cabin warning controller: filters five status switches and drives a
// registered buzzer output. Performs no arithmetic despite the module name.
module half_adder
  import car_warn_pkg::*;
#(
  parameter int DEBOUNCE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic D,
  input  logic H,
  input  logic E,
  input  logic S,
  input  logic B,
  output logic x
);

  logic [NUM_IN-1:0] w_raw;
  logic [NUM_IN-1:0] w_filt;
  logic              r_x;

  always_comb begin
    w_raw        = '0;
    w_raw[IDX_D] = D;
    w_raw[IDX_H] = H;
    w_raw[IDX_E] = E;
    w_raw[IDX_S] = S;
    w_raw[IDX_B] = B;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_filter
      switch_filter #(
        .DEBOUNCE(DEBOUNCE)
      ) u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_sw  (w_raw[gi]),
        .o_filt(w_filt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= 1'b0;
    end else begin
      r_x <= warn_fn(w_filt);
    end
  end

  assign x = r_x;

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for the cabin warning controller; one instance without
// debounce and one with DEBOUNCE = 3 share the same switch inputs.
module tb_half_adder;

  logic clk;
  logic rst_n;
  logic D, H, E, S, B;
  logic x0;
  logic x3;

  int checks   = 0;
  int failures = 0;
  bit sb_q[$];

  half_adder #(.DEBOUNCE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .D(D), .H(H), .E(E), .S(S), .B(B), .x(x0)
  );

  half_adder #(.DEBOUNCE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .D(D), .H(H), .E(E), .S(S), .B(B), .x(x3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic bit model(input bit h, input bit d, input bit e, input bit s, input bit b);
    return (h & d & ~e) | (e & ~s) | (e & d & ~b);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit h, input bit s, input bit b, input bit d, input bit e);
    H = h; S = s; B = b; D = d; E = e;
  endtask

  task automatic test_reset;
    bit exp;
    drive(1, 1, 1, 1, 1);
    rst_n = 1'b0;
    tick(3);
    sb_q.push_back(1'b0);
    sb_q.push_back(1'b0);
    exp = sb_q.pop_front();
    checks++;
    if (x0 !== exp) begin
      failures++;
      $display("FAIL reset_x0: x=%0b expected %0b", x0, exp);
    end
    exp = sb_q.pop_front();
    checks++;
    if (x3 !== exp) begin
      failures++;
      $display("FAIL reset_x3: x=%0b expected %0b", x3, exp);
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick(12);
    $display("reset: x0=%0b x3=%0b", x0, x3);
  endtask

  task automatic test_sweep;
    bit exp;
    for (int i = 0; i < 32; i++) begin
      bit [4:0] v;
      v = i[4:0];
      drive(v[4], v[3], v[2], v[1], v[0]);
      sb_q.push_back(model(v[4], v[1], v[0], v[3], v[2]));
      sb_q.push_back(model(v[4], v[1], v[0], v[3], v[2]));
      tick(3);
      exp = sb_q.pop_front();
      checks++;
      if (x0 !== exp) begin
        failures++;
        $display("FAIL sweep_edge3 HSBDE=%05b: x=%0b expected %0b", v, x0, exp);
      end
      tick(2);
      exp = sb_q.pop_front();
      checks++;
      if (x0 !== exp) begin
        failures++;
        $display("FAIL sweep_hold HSBDE=%05b: x=%0b expected %0b", v, x0, exp);
      end
      $display("sweep HSBDE=%05b x=%0b", v, x0);
    end
  endtask

  task automatic test_async_reset;
    bit exp;
    drive(1, 0, 0, 1, 0);
    tick(12);
    sb_q.push_back(1'b1);
    exp = sb_q.pop_front();
    checks++;
    if (x0 !== exp) begin
      failures++;
      $display("FAIL lights_before_reset: x=%0b expected %0b", x0, exp);
    end
    #3;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(1'b0);
    exp = sb_q.pop_front();
    checks++;
    if (x0 !== exp) begin
      failures++;
      $display("FAIL async_reset_drop: x=%0b expected %0b", x0, exp);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    sb_q.push_back(1'b0);
    sb_q.push_back(1'b0);
    sb_q.push_back(1'b1);
    tick(1);
    exp = sb_q.pop_front();
    checks++;
    if (x0 !== exp) begin
      failures++;
      $display("FAIL post_release_edge1: x=%0b expected %0b", x0, exp);
    end
    tick(1);
    exp = sb_q.pop_front();
    checks++;
    if (x0 !== exp) begin
      failures++;
      $display("FAIL post_release_edge2: x=%0b expected %0b", x0, exp);
    end
    tick(2);
    exp = sb_q.pop_front();
    checks++;
    if (x0 !== exp) begin
      failures++;
      $display("FAIL post_release_recover: x=%0b expected %0b", x0, exp);
    end
    $display("async reset: x0=%0b after recovery", x0);
  endtask

  task automatic test_debounce_accept;
    bit exp;
    drive(0, 0, 0, 0, 0);
    tick(12);
    sb_q.push_back(1'b0);
    exp = sb_q.pop_front();
    checks++;
    if (x3 !== exp) begin
      failures++;
      $display("FAIL db_idle: x=%0b expected %0b", x3, exp);
    end
    drive(0, 0, 0, 0, 1);
    sb_q.push_back(1'b1);
    sb_q.push_back(1'b0);
    sb_q.push_back(1'b1);
    tick(3);
    exp = sb_q.pop_front();
    checks++;
    if (x0 !== exp) begin
      failures++;
      $display("FAIL nodb_belt_edge3: x=%0b expected %0b", x0, exp);
    end
    tick(2);
    exp = sb_q.pop_front();
    checks++;
    if (x3 !== exp) begin
      failures++;
      $display("FAIL db_belt_edge5_early: x=%0b expected %0b", x3, exp);
    end
    tick(1);
    exp = sb_q.pop_front();
    checks++;
    if (x3 !== exp) begin
      failures++;
      $display("FAIL db_belt_edge6: x=%0b expected %0b", x3, exp);
    end
    $display("debounce accept: x3=%0b", x3);
  endtask

  task automatic test_debounce_reject;
    bit exp;
    bit saw_high;
    drive(0, 0, 0, 0, 0);
    tick(12);
    drive(0, 0, 0, 0, 1);
    tick(2);
    drive(0, 0, 0, 0, 0);
    saw_high = 1'b0;
    sb_q.push_back(1'b0);
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (x3 === 1'b1) saw_high = 1'b1;
    end
    exp = sb_q.pop_front();
    checks++;
    if (saw_high !== exp) begin
      failures++;
      $display("FAIL db_glitch_reject: x_high_seen=%0b expected %0b", saw_high, exp);
    end
    $display("debounce reject: x3 high seen=%0b", saw_high);
  endtask

  task automatic test_simultaneous;
    bit exp;
    drive(0, 0, 0, 0, 1);
    tick(12);
    sb_q.push_back(1'b1);
    sb_q.push_back(1'b1);
    exp = sb_q.pop_front();
    checks++;
    if (x0 !== exp) begin
      failures++;
      $display("FAIL simul_pre_x0: x=%0b expected %0b", x0, exp);
    end
    exp = sb_q.pop_front();
    checks++;
    if (x3 !== exp) begin
      failures++;
      $display("FAIL simul_pre_x3: x=%0b expected %0b", x3, exp);
    end
    drive(1, 1, 0, 1, 0);
    for (int c = 0; c < 12; c++) begin
      sb_q.push_back(model(1, 1, 0, 1, 0) | model(0, 0, 1, 0, 0));
      sb_q.push_back(model(1, 1, 0, 1, 0) | model(0, 0, 1, 0, 0));
      tick(1);
      exp = sb_q.pop_front();
      checks++;
      if (x0 !== exp) begin
        failures++;
        $display("FAIL simul_gap_x0 cycle %0d: x=%0b expected %0b", c, x0, exp);
      end
      exp = sb_q.pop_front();
      checks++;
      if (x3 !== exp) begin
        failures++;
        $display("FAIL simul_gap_x3 cycle %0d: x=%0b expected %0b", c, x3, exp);
      end
    end
    $display("simultaneous: x0=%0b x3=%0b", x0, x3);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_sweep();
    test_async_reset();
    test_debounce_accept();
    test_debounce_reject();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
